// File: rtl/tl_pkg.sv
// Shared TileLink-UL encodings for the master: opcodes, beat field offsets and FSM states.
package tl_pkg;

  localparam int TL_W       = 101;
  localparam int TL_ADDR_W  = 27;
  localparam int TL_DATA_W  = 64;

  localparam int OPCODE_LSB = 98;
  localparam int PARAM_LSB  = 95;
  localparam int SIZE_LSB   = 91;
  localparam int ADDR_LSB   = 64;
  localparam int DENIED_BIT = 90;

  localparam logic [2:0] A_PUT_FULL = 3'd0;
  localparam logic [2:0] A_GET_OP   = 3'd4;
  localparam logic [2:0] D_ACK      = 3'd0;
  localparam logic [2:0] D_ACK_DATA = 3'd1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    A_PUT  = 3'd1,
    A_GET  = 3'd2,
    D_WAIT = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic logic [TL_W-1:0] a_beat(input logic [2:0]           opcode,
                                             input logic [3:0]           size,
                                             input logic [TL_ADDR_W-1:0] addr,
                                             input logic [TL_DATA_W-1:0] data);
    logic [TL_W-1:0] beat;
    beat = '0;
    beat[OPCODE_LSB +: 3]       = opcode;
    beat[PARAM_LSB +: 3]        = 3'd0;
    beat[SIZE_LSB +: 4]         = size;
    beat[ADDR_LSB +: TL_ADDR_W] = addr;
    beat[0 +: TL_DATA_W]        = data;
    return beat;
  endfunction

endpackage

// File: rtl/tilelink_master_ul.sv
// TileLink-UL master: turns one user command into a PutFullData burst or a Get,
// then collects the D-channel response with error and timeout detection.
module tilelink_master_ul
  import tl_pkg::*;
#(
  parameter int ADDR_W   = 27,
  parameter int DATA_W   = 64,
  parameter int MAX_SIZE = 6,
  parameter int TIMEOUT  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_size,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              resp_done,
  output logic              resp_err,
  output logic              m_a_valid,
  input  logic              s_a_ready,
  output logic [TL_W-1:0]   o_a_data,
  input  logic              s_d_valid,
  output logic              m_d_ready,
  input  logic [TL_W-1:0]   i_d_data
);

  localparam int BEAT_W = (MAX_SIZE > 3) ? MAX_SIZE - 3 : 1;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [3:0] MAX_SIZE_L = 4'(MAX_SIZE);

  state_t state, state_next;

  logic              is_write;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        size_q;
  logic [BEAT_W-1:0] beats_last, beats_last_next, beat_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              err_q;

  logic size_bad, last_beat, d_fire, d_bad, idle_expired;
  logic unused_d;

  assign size_bad     = cmd_size > MAX_SIZE_L;
  assign last_beat    = beat_cnt == beats_last;
  assign d_fire       = s_d_valid && (is_write || rd_ready);
  assign d_bad        = i_d_data[DENIED_BIT] ||
                        (i_d_data[OPCODE_LSB +: 3] != (is_write ? D_ACK : D_ACK_DATA));
  assign idle_expired = idle_cnt == IDLE_W'(TIMEOUT - 1);
  assign unused_d     = ^{i_d_data[PARAM_LSB +: 3], i_d_data[SIZE_LSB +: 4], i_d_data[ADDR_LSB +: 26]};

  // Beats are stored as count-minus-one so one 8-beat burst fits in BEAT_W bits.
  always_comb begin
    beats_last_next = '0;
    if (cmd_size > 4'd3)
      beats_last_next = BEAT_W'((32'd1 << (cmd_size - 4'd3)) - 32'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    rd_valid   = 1'b0;
    rd_data    = '0;
    rd_last    = 1'b0;
    resp_done  = 1'b0;
    resp_err   = 1'b0;
    m_a_valid  = 1'b0;
    o_a_data   = '0;
    m_d_ready  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && !rst)
          state_next = size_bad ? DONE : (cmd_write ? A_PUT : A_GET);
      end
      A_PUT: begin
        m_a_valid = wr_valid;
        wr_ready  = s_a_ready;
        o_a_data  = a_beat(A_PUT_FULL, size_q, TL_ADDR_W'(addr_q), TL_DATA_W'(wr_data));
        if (wr_valid && s_a_ready && last_beat) state_next = D_WAIT;
      end
      A_GET: begin
        m_a_valid = 1'b1;
        o_a_data  = a_beat(A_GET_OP, size_q, TL_ADDR_W'(addr_q), '0);
        if (s_a_ready) state_next = D_WAIT;
      end
      D_WAIT: begin
        if (is_write) begin
          m_d_ready = 1'b1;
        end else begin
          m_d_ready = rd_ready;
          rd_valid  = s_d_valid;
          rd_data   = DATA_W'(i_d_data[0 +: TL_DATA_W]);
          rd_last   = s_d_valid && last_beat;
        end
        if (d_fire && (is_write || last_beat))
          state_next = DONE;
        else if (!d_fire && idle_expired)
          state_next = DONE;
      end
      DONE: begin
        resp_done  = 1'b1;
        resp_err   = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // beat_cnt is shared: it counts A beats for a write, then D beats for a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_write   <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      beats_last <= '0;
      beat_cnt   <= '0;
      idle_cnt   <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            is_write   <= cmd_write;
            addr_q     <= cmd_addr;
            size_q     <= cmd_size;
            beats_last <= beats_last_next;
            beat_cnt   <= '0;
            idle_cnt   <= '0;
            err_q      <= size_bad;
          end
        end
        A_PUT: begin
          if (wr_valid && s_a_ready)
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        end
        D_WAIT: begin
          if (d_fire) begin
            idle_cnt <= '0;
            beat_cnt <= beat_cnt + 1'b1;
            if (d_bad) err_q <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
            if (idle_expired) err_q <= 1'b1;
          end
        end
        DONE: err_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tilelink_master_ul.sv
// Directed plus randomized bench for tilelink_master_ul against a transaction-level model.
module tb_tilelink_master_ul;

  localparam int ADDR_W   = 27;
  localparam int DATA_W   = 64;
  localparam int MAX_SIZE = 6;
  localparam int TIMEOUT  = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [3:0]        cmd_size = '0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              resp_done;
  logic              resp_err;
  logic              m_a_valid;
  logic              s_a_ready = 1'b0;
  logic [100:0]      o_a_data;
  logic              s_d_valid = 1'b0;
  logic              m_d_ready;
  logic [100:0]      i_d_data = '0;

  int vectors = 0;
  int miscompares = 0;

  tilelink_master_ul #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_SIZE(MAX_SIZE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .resp_done(resp_done), .resp_err(resp_err),
    .m_a_valid(m_a_valid), .s_a_ready(s_a_ready), .o_a_data(o_a_data),
    .s_d_valid(s_d_valid), .m_d_ready(m_d_ready), .i_d_data(i_d_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [100:0] aBeat(input logic [2:0] op, input logic [3:0] size,
                                         input logic [26:0] addr, input logic [63:0] data);
    return {op, 3'd0, size, addr, data};
  endfunction

  function automatic int beatsFor(input int size);
    return (size <= 3) ? 1 : (1 << (size - 3));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkQuiet(input string tag, input logic expCmdReady);
    checkOutput({tag, "_flags"},
                128'({cmd_ready, wr_ready, rd_valid, rd_last, resp_done, resp_err, m_a_valid, m_d_ready}),
                128'({expCmdReady, 7'd0}));
    checkOutput({tag, "_a_data"}, 128'(o_a_data), 128'(0));
    checkOutput({tag, "_rd_data"}, 128'(rd_data), 128'(0));
  endtask

  task automatic applyStimulus(input logic write, input logic [3:0] size, input logic [26:0] addr);
    cmd_valid = 1'b1;
    cmd_write = write;
    cmd_size  = size;
    cmd_addr  = addr;
    #1;
    checkOutput("cmd_ready", 128'(cmd_ready), 128'(1));
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic finishResponse(input string tag, input logic expErr);
    checkOutput({tag, "_resp_done"}, 128'(resp_done), 128'(1));
    checkOutput({tag, "_resp_err"}, 128'(resp_err), 128'(expErr));
    tick;
    checkOutput({tag, "_after_done"}, 128'({resp_done, cmd_ready}), 128'(2'b01));
  endtask

  task automatic runWrite(input logic [3:0] size, input logic [26:0] addr, input bit seq,
                          input bit stall, input logic denied, input logic [2:0] dOp);
    logic [63:0] q[$];
    int n, i, cyc, stallAt, stalls;
    n = beatsFor(size);
    for (int k = 0; k < n; k++) q.push_back(seq ? 64'(k + 5) : {$urandom, $urandom});
    stallAt = (n > 3) ? 3 : 0;
    stalls = 0;
    applyStimulus(1'b1, size, addr);
    i = 0;
    cyc = 0;
    while (i < n && cyc < 200) begin
      wr_valid = 1'b1;
      wr_data  = q[i];
      s_a_ready = 1'b1;
      if (stall && i == stallAt && stalls < 3) begin
        s_a_ready = 1'b0;
        stalls++;
      end
      #1;
      checkOutput("put_valid", 128'(m_a_valid), 128'(1));
      checkOutput("put_beat", 128'(o_a_data), 128'(aBeat(3'd0, size, addr, q[i])));
      checkOutput("put_wr_ready", 128'(wr_ready), 128'(s_a_ready));
      tick;
      if (s_a_ready) i++;
      cyc++;
    end
    if (i < n) checkOutput("put_bound", 128'(0), 128'(1));
    wr_valid  = 1'b0;
    s_a_ready = 1'b0;
    #1;
    checkOutput("put_dwait", 128'({m_a_valid, m_d_ready, resp_done}), 128'(3'b010));
    repeat ($urandom_range(0, 2)) tick;
    s_d_valid = 1'b1;
    i_d_data  = {dOp, 3'd0, size, denied, 26'd0, 64'd0};
    tick;
    s_d_valid = 1'b0;
    finishResponse("write", denied || (dOp != 3'd0));
  endtask

  task automatic runRead(input logic [3:0] size, input logic [26:0] addr, input bit seq,
                         input bit toggle, input int errBeat, input int aStall);
    logic [63:0] q[$];
    int n, i, cyc;
    logic sv;
    n = beatsFor(size);
    for (int k = 0; k < n; k++) q.push_back(seq ? 64'(k + 5) : {$urandom, $urandom});
    applyStimulus(1'b0, size, addr);
    s_a_ready = 1'b0;
    for (int k = 0; k <= aStall; k++) begin
      if (k == aStall) s_a_ready = 1'b1;
      #1;
      checkOutput("get_valid", 128'(m_a_valid), 128'(1));
      checkOutput("get_beat", 128'(o_a_data), 128'(aBeat(3'd4, size, addr, 64'd0)));
      tick;
    end
    s_a_ready = 1'b0;
    i = 0;
    cyc = 0;
    while (i < n && cyc < 200) begin
      sv        = toggle ? ($urandom_range(0, 3) != 0) : 1'b1;
      rd_ready  = toggle ? ((cyc % 2) == 0) : 1'b1;
      s_d_valid = sv;
      i_d_data  = {3'd1, 3'd0, size, (i == errBeat), 26'd0, q[i]};
      #1;
      checkOutput("rd_valid", 128'(rd_valid), 128'(sv));
      checkOutput("rd_d_ready", 128'(m_d_ready), 128'(rd_ready));
      checkOutput("rd_last", 128'(rd_last), 128'(sv && (i == n - 1)));
      if (sv) checkOutput("rd_data", 128'(rd_data), 128'(q[i]));
      tick;
      if (sv && rd_ready) i++;
      cyc++;
    end
    if (i < n) checkOutput("rd_bound", 128'(0), 128'(1));
    s_d_valid = 1'b0;
    rd_ready  = 1'b0;
    finishResponse("read", (errBeat >= 0) && (errBeat < n));
  endtask

  initial begin
    int n;
    $display("[TB] start");
    rst = 1'b1;
    tick;
    tick;
    checkQuiet("reset", 1'b0);
    rst = 1'b0;
    tick;
    checkQuiet("idle", 1'b1);

    runWrite(4'd6, 27'd0, 1'b1, 1'b0, 1'b0, 3'd0);
    runRead(4'd6, 27'd0, 1'b1, 1'b0, -1, 0);
    runWrite(4'd6, 27'h123_4567, 1'b0, 1'b1, 1'b0, 3'd0);
    runRead(4'd6, 27'h456_7890, 1'b0, 1'b1, -1, 2);
    runWrite(4'd3, 27'h0AB_CDEF, 1'b0, 1'b0, 1'b1, 3'd0);
    runWrite(4'd4, 27'h000_0040, 1'b0, 1'b0, 1'b0, 3'd1);
    runRead(4'd5, 27'h7FF_FFE0, 1'b0, 1'b1, 2, 1);

    applyStimulus(1'b1, 4'd7, 27'h000_0100);
    checkOutput("illegal_no_a", 128'({m_a_valid, wr_ready}), 128'(0));
    finishResponse("illegal", 1'b1);

    applyStimulus(1'b0, 4'd3, 27'h000_0200);
    s_a_ready = 1'b1;
    tick;
    s_a_ready = 1'b0;
    n = 0;
    checkOutput("timeout_early", 128'(resp_done), 128'(0));
    while (!resp_done && n < 400) begin
      tick;
      n++;
    end
    checkOutput("timeout_cycles", 128'(n), 128'(TIMEOUT));
    finishResponse("timeout", 1'b1);

    applyStimulus(1'b1, 4'd6, 27'd0);
    s_a_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1;
      wr_data  = 64'(k + 5);
      tick;
    end
    wr_data = 64'd8;
    rst = 1'b1;
    tick;
    s_d_valid = 1'b1;
    i_d_data  = {3'd0, 3'd0, 4'd6, 1'b0, 26'd0, 64'd0};
    #1;
    checkQuiet("mid_reset", 1'b0);
    rst = 1'b0;
    wr_valid = 1'b0;
    s_a_ready = 1'b0;
    tick;
    checkQuiet("late_d", 1'b1);
    tick;
    checkQuiet("late_d_after", 1'b1);
    s_d_valid = 1'b0;

    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 1) == 1)
        runWrite(4'($urandom_range(0, MAX_SIZE)), 27'($urandom), 1'b0, 1'($urandom_range(0, 1)),
                 1'b0, 3'd0);
      else
        runRead(4'($urandom_range(0, MAX_SIZE)), 27'($urandom), 1'b0, 1'($urandom_range(0, 1)),
                -1, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tilelink_master_ul.md
TILELINK_MASTER_UL -- requirements
Module: tilelink_master_ul

Interface
REQ-001 SHALL have parameter ADDR_W, default 27, address width.
REQ-002 SHALL have parameter DATA_W, default 64, data beat width.
REQ-003 SHALL have parameter MAX_SIZE, default 6, largest legal log2(bytes) per transfer.
REQ-004 SHALL have parameter TIMEOUT, default 256, idle cycles allowed in D_WAIT before abort.
REQ-005 SHALL have ports, one per line:
  clk  in  1  single clock, all logic on rising edge
  rst  in  1  synchronous active-high reset
  cmd_valid  in  1  user command offered
  cmd_ready  out  1  command accepted when both high
  cmd_write  in  1  1 = PutFullData, 0 = Get
  cmd_addr  in  ADDR_W  byte address
  cmd_size  in  4  log2(bytes)
  wr_valid  in  1  write beat offered
  wr_ready  out  1  write beat consumed
  wr_data  in  DATA_W  write beat
  rd_valid  out  1  read beat valid
  rd_ready  in  1  user accepts read beat
  rd_data  out  DATA_W  read beat
  rd_last  out  1  final read beat
  resp_done  out  1  one-cycle pulse, transaction finished
  resp_err  out  1  qualifies resp_done: denied, bad opcode, illegal size or timeout
  m_a_valid  out  1  A-channel valid
  s_a_ready  in  1  A-channel ready from slave
  o_a_data  out  101  A beat {opcode[100:98], param[97:95], size[94:91], address[90:64], data[63:0]}
  s_d_valid  in  1  D-channel valid from slave
  m_d_ready  out  1  D-channel ready
  i_d_data  in  101  D beat {opcode[100:98], param[97:95], size[94:91], denied[90], rsvd[89:64], data[63:0]}

Function
REQ-006 SHALL use FSM states IDLE, A_PUT, A_GET, D_WAIT, DONE; one transaction outstanding.
REQ-007 SHALL assert cmd_ready only in IDLE; on acceptance register write, addr, size; beats = 1 if size<=3 else 2^(size-3).
REQ-008 SHALL, for accepted cmd_size>MAX_SIZE, issue no bus traffic and go to DONE with resp_err=1.
REQ-009 SHALL in A_PUT drive m_a_valid=wr_valid, wr_ready=s_a_ready, o_a_data={3'd0,3'd0,size,addr,wr_data}; same address every beat.
REQ-010 SHALL count a beat per cycle with m_a_valid&&s_a_ready; after final beat go to D_WAIT.
REQ-011 SHALL in A_GET drive m_a_valid=1, o_a_data={3'd4,3'd0,size,addr,64'd0}; on s_a_ready go to D_WAIT.
REQ-012 SHALL hold o_a_data stable while m_a_valid=1 and s_a_ready=0; m_a_valid=0 outside A_PUT/A_GET.
REQ-013 SHALL in D_WAIT for write set m_d_ready=1; expect one AccessAck (opcode 0); then DONE.
REQ-014 SHALL in D_WAIT for read set m_d_ready=rd_ready, rd_valid=s_d_valid, rd_data=i_d_data[63:0]; expect beats AccessAckData (opcode 1); rd_last on final beat; then DONE.
REQ-015 SHALL sticky-set error on any D beat with denied=1 or unexpected opcode; read data still forwarded, beat count unaffected.
REQ-016 SHALL count cycles in D_WAIT with no D handshake; reset count on each handshake; at TIMEOUT go to DONE with resp_err=1.
REQ-017 SHALL in DONE pulse resp_done one cycle with resp_err, clear error, return to IDLE; cmd_ready low in DONE.
REQ-018 SHALL ignore s_d_valid outside D_WAIT (m_d_ready=0).
REQ-019 SHALL allow back-to-back: new command accepted the cycle after DONE.

Reset
REQ-020 SHALL on rst=1 at a clock edge go to IDLE and clear counters, error, all outputs to 0 (cmd_ready becomes 1 the cycle after release).
REQ-021 SHALL on reset mid-transaction abandon it with no resp_done; late D beats after reset are ignored per REQ-018.

Structure
REQ-022 SHALL place A/D opcode constants (PutFullData=0, Get=4, AccessAck=0, AccessAckData=1), field bit offsets, and FSM state encoding in shared package tl_pkg.
REQ-023 SHALL be one flat module; no sub-module required.

Verification
REQ-024 Write size=6 addr=0, wr_data 5..12, s_a_ready=1 -> 8 A beats opcode 0 size 6 addr 0 data 5..12; AccessAck -> resp_done=1 resp_err=0.
REQ-025 Read size=6 addr=0, slave returns 8 AccessAckData beats 5..12 -> rd_data 5..12, rd_last only on 12, resp_done err=0.
REQ-026 s_a_ready low 3 cycles mid-burst and rd_ready toggling -> o_a_data stable while stalled, no beat lost or duplicated.
REQ-027 cmd_size=7 -> no m_a_valid, resp_done+resp_err next cycle; D beat with denied=1 -> resp_err=1.
REQ-028 No D response for 256 cycles -> resp_done+resp_err, back to IDLE; rst=1 during A_PUT beat 3 -> all outputs 0, no resp_done.
